uc_dispara_tiro: RTL and testbench

Control unit that spawns shots. It is the writer of the shot memory that the shot-movement controller scans. On a fire request it scans shot slots 0..N_TIROS-1 for the first slot with loaded=0, then writes the ship's position, the ship's direction as the shot opcode, and loaded=1 into that slot. The top level uses `ocupado` to keep the fire and move controllers from accessing the shot memory at the same time.

---
 rtl/uc_dispara_tiro.sv | 169 ++++++++++++++++
 tb/tb_uc_dispara_tiro.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_dispara_tiro.sv
// Shot-spawn control unit: finds the first free shot slot and writes the ship's
// position/direction into it. Optional post-fire lockout under DISPARO_COOLDOWN_EN.
module uc_dispara_tiro #(
   parameter int N_TIROS = 8,
   parameter int ADDR_W  = 3,
   parameter int COORD_W = 10
`ifdef DISPARO_COOLDOWN_EN
   ,
   parameter int COOLDOWN = 16
`endif
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               dispara,
   input  logic               bloqueio,
   input  logic [COORD_W-1:0] nave_x,
   input  logic [COORD_W-1:0] nave_y,
   input  logic [1:0]         direcao_nave,
   input  logic               mem_loaded_rd,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_we,
   output logic [COORD_W-1:0] mem_x,
   output logic [COORD_W-1:0] mem_y,
   output logic [1:0]         mem_opcode,
   output logic               mem_loaded_wr,
   output logic               ocupado,
   output logic               disparo_concluido,
   output logic               sem_slot,
   output logic [4:0]         db_estado_dispara
);

   typedef enum logic [3:0] {
      S_INICIO         = 4'd0,
      S_ESPERA         = 4'd1,
      S_AGUARDA_LIBER  = 4'd2,
      S_RESETA_INDICE  = 4'd3,
      S_VERIFICA_SLOT  = 4'd4,
      S_INCREMENTA     = 4'd5,
      S_GRAVA          = 4'd6,
      S_SINALIZA_OK    = 4'd7,
      S_SINALIZA_CHEIO = 4'd8
`ifdef DISPARO_COOLDOWN_EN
      ,
      S_COOLDOWN       = 4'd9
`endif
   } estado_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TIROS - 1);

`ifdef DISPARO_COOLDOWN_EN
   localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
   logic [CNT_W-1:0] r_cnt;
`endif

   estado_t             r_state;
   estado_t             w_next;
   logic [ADDR_W-1:0]   r_idx;
   logic [COORD_W-1:0]  r_x;
   logic [COORD_W-1:0]  r_y;
   logic [1:0]          r_op;
   logic                r_we;
   logic                r_loaded_wr;
   logic                r_ocupado;
   logic                r_concluido;
   logic                r_sem_slot;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INICIO:         w_next = S_ESPERA;
         S_ESPERA: begin
            if (dispara)
               w_next = bloqueio ? S_AGUARDA_LIBER : S_RESETA_INDICE;
         end
         S_AGUARDA_LIBER: begin
            if (!bloqueio)
               w_next = S_RESETA_INDICE;
         end
         S_RESETA_INDICE:  w_next = S_VERIFICA_SLOT;
         S_VERIFICA_SLOT: begin
            if (!mem_loaded_rd)
               w_next = S_GRAVA;
            else if (r_idx == LAST_IDX)
               w_next = S_SINALIZA_CHEIO;
            else
               w_next = S_INCREMENTA;
         end
         S_INCREMENTA:     w_next = S_VERIFICA_SLOT;
         S_GRAVA:          w_next = S_SINALIZA_OK;
`ifdef DISPARO_COOLDOWN_EN
         S_SINALIZA_OK:    w_next = S_COOLDOWN;
         S_COOLDOWN: begin
            if (r_cnt == '0)
               w_next = S_ESPERA;
         end
`else
         S_SINALIZA_OK:    w_next = S_ESPERA;
`endif
         S_SINALIZA_CHEIO: w_next = S_ESPERA;
         default:          w_next = S_INICIO;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_INICIO;
         r_idx       <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_op        <= '0;
         r_we        <= 1'b0;
         r_loaded_wr <= 1'b0;
         r_ocupado   <= 1'b0;
         r_concluido <= 1'b0;
         r_sem_slot  <= 1'b0;
`ifdef DISPARO_COOLDOWN_EN
         r_cnt       <= '0;
`endif
      end else begin
         r_state     <= w_next;
         r_we        <= (w_next == S_GRAVA);
         r_loaded_wr <= (w_next == S_GRAVA);
         r_ocupado   <= (w_next != S_ESPERA) && (w_next != S_INICIO);
         r_concluido <= (w_next == S_SINALIZA_OK);
         r_sem_slot  <= (w_next == S_SINALIZA_CHEIO);
         if (r_state == S_RESETA_INDICE) begin
            r_idx <= '0;
            r_x   <= nave_x;
            r_y   <= nave_y;
            r_op  <= direcao_nave;
         end
         if (r_state == S_INCREMENTA)
            r_idx <= r_idx + 1'b1;
`ifdef DISPARO_COOLDOWN_EN
         if (r_state == S_SINALIZA_OK)
            r_cnt <= CNT_W'(COOLDOWN - 1);
         else if (r_state == S_COOLDOWN && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
`endif
      end
   end

   always_comb begin
      db_estado_dispara = 5'b11111;
      case (r_state)
         S_INICIO, S_ESPERA, S_AGUARDA_LIBER, S_RESETA_INDICE, S_VERIFICA_SLOT,
         S_INCREMENTA, S_GRAVA, S_SINALIZA_OK, S_SINALIZA_CHEIO:
            db_estado_dispara = {1'b0, r_state};
`ifdef DISPARO_COOLDOWN_EN
         S_COOLDOWN:
            db_estado_dispara = {1'b0, r_state};
`endif
         default:
            db_estado_dispara = 5'b11111;
      endcase
   end

   assign mem_addr          = r_idx;
   assign mem_we            = r_we;
   assign mem_x             = r_x;
   assign mem_y             = r_y;
   assign mem_opcode        = r_op;
   assign mem_loaded_wr     = r_loaded_wr;
   assign ocupado           = r_ocupado;
   assign disparo_concluido = r_concluido;
   assign sem_slot          = r_sem_slot;

endmodule

// File: tb/tb_uc_dispara_tiro.sv
// Directed bench for uc_dispara_tiro with a behavioural shot-slot memory and
// an expected-write queue.
module tb_uc_dispara_tiro;

   localparam int ADDR_W  = 3;
   localparam int COORD_W = 10;
   localparam int WW      = ADDR_W + 2 * COORD_W + 3;

   logic               clock;
   logic               reset;
   logic               dispara;
   logic               bloqueio;
   logic [COORD_W-1:0] nave_x;
   logic [COORD_W-1:0] nave_y;
   logic [1:0]         direcao_nave;
   logic               mem_loaded_rd;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_we;
   logic [COORD_W-1:0] mem_x;
   logic [COORD_W-1:0] mem_y;
   logic [1:0]         mem_opcode;
   logic               mem_loaded_wr;
   logic               ocupado;
   logic               disparo_concluido;
   logic               sem_slot;
   logic [4:0]         db_estado_dispara;

   logic [7:0]         slot_loaded;
   logic [7:0]         preload_val;
   logic               do_preload;
   logic               keep_free;

   logic [WW-1:0]      exp_q[$];
   int                 n_checks = 0;
   int                 n_errors = 0;
   int                 n_writes = 0;
   int                 we_at, done_at, sem_at;

   uc_dispara_tiro dut (
      .clock             (clock),
      .reset             (reset),
      .dispara           (dispara),
      .bloqueio          (bloqueio),
      .nave_x            (nave_x),
      .nave_y            (nave_y),
      .direcao_nave      (direcao_nave),
      .mem_loaded_rd     (mem_loaded_rd),
      .mem_addr          (mem_addr),
      .mem_we            (mem_we),
      .mem_x             (mem_x),
      .mem_y             (mem_y),
      .mem_opcode        (mem_opcode),
      .mem_loaded_wr     (mem_loaded_wr),
      .ocupado           (ocupado),
      .disparo_concluido (disparo_concluido),
      .sem_slot          (sem_slot),
      .db_estado_dispara (db_estado_dispara)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // shot-slot memory model: loaded bits only, combinational read
   assign mem_loaded_rd = slot_loaded[mem_addr];
   always @(posedge clock) begin
      if (do_preload)
         slot_loaded <= preload_val;
      else if (mem_we && !keep_free)
         slot_loaded[mem_addr] <= mem_loaded_wr;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WW-1:0] pack(input int a, input int x, input int y, input int op);
      return {ADDR_W'(a), COORD_W'(x), COORD_W'(y), 2'(op), 1'b1};
   endfunction

   // scoreboard: every write strobe must match the head of exp_q
   always @(negedge clock) begin
      if (!reset && mem_we) begin
         n_writes++;
         if (exp_q.size() == 0)
            check("unexpected_write", 32'd1, 32'd0);
         else
            check("write_fields", 32'({mem_addr, mem_x, mem_y, mem_opcode, mem_loaded_wr}),
                  32'(exp_q.pop_front()));
      end
   end

   // driver tasks
   task automatic preload(input logic [7:0] mask);
      do_preload  = 1'b1;
      preload_val = mask;
      @(posedge clock);
      @(negedge clock);
      do_preload  = 1'b0;
   endtask

   // counts edges from now; ship moves after the latch edge to prove values are held
   task automatic run_until(input int budget, output int w_at, output int d_at, output int s_at);
      w_at = -1;
      d_at = -1;
      s_at = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (i == 1) dispara = 1'b0;
         if (i == 2) begin
            nave_x = ~nave_x;
            nave_y = ~nave_y;
         end
         if (mem_we && w_at < 0) w_at = i;
         if (disparo_concluido && d_at < 0) d_at = i;
         if (sem_slot && s_at < 0) s_at = i;
         if (d_at >= 0 || s_at >= 0) break;
      end
   endtask

   task automatic fire(input int x, input int y, input int dir,
                       output int w_at, output int d_at, output int s_at);
      nave_x       = COORD_W'(x);
      nave_y       = COORD_W'(y);
      direcao_nave = 2'(dir);
      dispara      = 1'b1;
      run_until(40, w_at, d_at, s_at);
   endtask

   task automatic expect_idle(input string tag);
      @(posedge clock);
      @(negedge clock);
      check({tag, "_db"}, 32'(db_estado_dispara), 32'd1);
      check({tag, "_ocupado"}, 32'(ocupado), 32'd0);
   endtask

   initial begin
      reset        = 1'b1;
      dispara      = 1'b0;
      bloqueio     = 1'b0;
      nave_x       = '0;
      nave_y       = '0;
      direcao_nave = '0;
      do_preload   = 1'b0;
      preload_val  = '0;
      keep_free    = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_outputs", 32'({mem_addr, mem_we, mem_x, mem_y, mem_opcode, mem_loaded_wr,
                                ocupado, disparo_concluido, sem_slot}), 32'd0);
      check("rst_db", 32'(db_estado_dispara), 32'd0);
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("after_rst_db", 32'(db_estado_dispara), 32'd1);
      preload(8'h00);

      // all slots free
      exp_q.push_back(pack(0, 100, 50, 2));
      fire(100, 50, 2, we_at, done_at, sem_at);
      check("free0_we_cycle", 32'(we_at), 32'd3);
      check("free0_done_cycle", 32'(done_at), 32'd4);
      check("free0_no_sem", 32'(sem_at), 32'hFFFF_FFFF);
      expect_idle("free0_idle");

      // slots 0-2 loaded, slot 3 free
      preload(8'h07);
      exp_q.push_back(pack(3, 200, 300, 1));
      fire(200, 300, 1, we_at, done_at, sem_at);
      check("slot3_we_cycle", 32'(we_at), 32'd9);
      check("slot3_done_cycle", 32'(done_at), 32'd10);
      expect_idle("slot3_idle");

      // every slot loaded
      preload(8'hFF);
      fire(5, 6, 3, we_at, done_at, sem_at);
      check("full_sem_cycle", 32'(sem_at), 32'd17);
      check("full_no_we", 32'(we_at), 32'hFFFF_FFFF);
      check("full_no_done", 32'(done_at), 32'hFFFF_FFFF);
      expect_idle("full_idle");

      // request held while the move controller owns the memory
      preload(8'h00);
      bloqueio     = 1'b1;
      nave_x       = 10'd7;
      nave_y       = 10'd9;
      direcao_nave = 2'd0;
      dispara      = 1'b1;
      @(posedge clock);
      @(negedge clock);
      dispara = 1'b0;
      check("block_enter_db", 32'(db_estado_dispara), 32'd2);
      repeat (4) begin
         @(posedge clock);
         @(negedge clock);
      end
      check("block_hold_db", 32'(db_estado_dispara), 32'd2);
      check("block_hold_ocupado", 32'(ocupado), 32'd1);
      bloqueio = 1'b0;
      exp_q.push_back(pack(0, 7, 9, 0));
      run_until(20, we_at, done_at, sem_at);
      check("block_we_cycle", 32'(we_at), 32'd3);
      check("block_done_cycle", 32'(done_at), 32'd4);
      expect_idle("block_idle");

      // reset in the middle of a scan
      preload(8'h0F);
      nave_x       = 10'd33;
      nave_y       = 10'd44;
      direcao_nave = 2'd3;
      dispara      = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (i == 1) dispara = 1'b0;
      end
      check("scan_db", 32'(db_estado_dispara), 32'd4);
      check("scan_addr", 32'(mem_addr), 32'd1);
      check("scan_ocupado", 32'(ocupado), 32'd1);
      reset = 1'b1;
      #1;
      check("midrst_outputs", 32'({mem_addr, mem_we, mem_x, mem_y, mem_opcode, mem_loaded_wr,
                                   ocupado, disparo_concluido, sem_slot}), 32'd0);
      check("midrst_db", 32'(db_estado_dispara), 32'd0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      expect_idle("midrst_idle");
      repeat (20) @(negedge clock);

`ifdef DISPARO_COOLDOWN_EN
      begin
         int first_we;
         int second_we;
         first_we  = -1;
         second_we = -1;
         preload(8'h00);
         keep_free    = 1'b1;
         nave_x       = 10'd1;
         nave_y       = 10'd2;
         direcao_nave = 2'd1;
         exp_q.push_back(pack(0, 1, 2, 1));
         exp_q.push_back(pack(0, 1, 2, 1));
         dispara = 1'b1;
         for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (mem_we) begin
               if (first_we < 0) first_we = i;
               else if (second_we < 0) second_we = i;
            end
            if (second_we >= 0) break;
         end
         dispara   = 1'b0;
         check("cool_first_we", 32'(first_we), 32'd3);
         check("cool_spacing", 32'(second_we - first_we), 32'd21);
         repeat (30) @(negedge clock);
         keep_free = 1'b0;
      end
      check("write_count", 32'(n_writes), 32'd5);
`else
      check("write_count", 32'(n_writes), 32'd3);
`endif
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
